// File: rtl/c7bifu_ibuf_if.sv
// Fetch-return / decode handshake bundle for the instruction buffer.
// master = fetch/decode side driving beats and consume; slave = the buffer.
interface c7bifu_ibuf_if #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned FETCH_WORDS = 2
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]               data_addr;
  logic [32*FETCH_WORDS-1:0] data;
  logic                      data_vld;
  logic                      flush;
  logic [1:0]                consume;
  logic                      iq_full;
  logic [CW-1:0]             iq_count;
  logic [31:0]               inst0_addr;
  logic [31:0]               inst0;
  logic                      inst0_vld;
  logic [31:0]               inst1_addr;
  logic [31:0]               inst1;
  logic                      inst1_vld;

  modport master (
    output data_addr, data, data_vld, flush, consume,
    input  iq_full, iq_count, inst0_addr, inst0, inst0_vld,
           inst1_addr, inst1, inst1_vld
  );

  modport slave (
    input  data_addr, data, data_vld, flush, consume,
    output iq_full, iq_count, inst0_addr, inst0, inst0_vld,
           inst1_addr, inst1, inst1_vld
  );
endinterface

// File: rtl/c7bifu_ibuf.sv
// Instruction buffer: takes fetch beats (dropping words before an unaligned
// entry point) and presents the two oldest instructions to a dual-lane decoder.
module c7bifu_ibuf #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned FETCH_WORDS = 2
) (
  input  logic          clk,
  input  logic          resetn,
  c7bifu_ibuf_if.slave  ibuf
);
  localparam int unsigned OW = $clog2(FETCH_WORDS);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = IW + 1;

  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   addr_d [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic [CW-1:0] count_q, count_d;

  logic          full;
  logic          wr_en;
  logic [OW-1:0] off;
  logic [31:0]   base;
  logic [CW-1:0] n_wr, n_rd, n_lanes;
  logic [IW-1:0] slot;
  logic [IW-1:0] rd_nxt;
  logic          unused_addr_lsb;

  // Full looks only at the registered count, so it never depends on this cycle's inputs.
  assign full            = count_q > CW'(DEPTH - FETCH_WORDS);
  assign unused_addr_lsb = ^ibuf.data_addr[1:0];

  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    count_d  = count_q;
    slot     = '0;
    off      = ibuf.data_addr[OW+1:2];
    base     = {ibuf.data_addr[31:OW+2], {(OW+2){1'b0}}};
    wr_en    = ibuf.data_vld && !full && !ibuf.flush;
    n_wr     = wr_en ? (CW'(FETCH_WORDS) - CW'(off)) : '0;
    n_lanes  = (count_q >= CW'(2)) ? CW'(2) : count_q;
    n_rd     = (CW'(ibuf.consume) < n_lanes) ? CW'(ibuf.consume) : n_lanes;

    if (ibuf.flush) begin
      wr_idx_d = '0;
      rd_idx_d = '0;
      count_d  = '0;
    end else begin
      // Words ahead of the entry offset are skipped; the rest pack from wr_idx.
      for (int k = 0; k < FETCH_WORDS; k++) begin
        if (wr_en && (k >= int'(off))) begin
          slot         = wr_idx_q + IW'(k) - IW'(off);
          addr_d[slot] = base + 32'(4 * k);
          data_d[slot] = ibuf.data[32*k +: 32];
        end
      end
      wr_idx_d = wr_idx_q + IW'(n_wr);
      rd_idx_d = rd_idx_q + IW'(n_rd);
      count_d  = count_q + n_wr - n_rd;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      count_q  <= '0;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      count_q  <= count_d;
    end
  end

  // Lanes read straight out of the head slots; no bypass from the write port.
  assign rd_nxt          = rd_idx_q + IW'(1);
  assign ibuf.iq_full    = full;
  assign ibuf.iq_count   = count_q;
  assign ibuf.inst0_addr = addr_q[rd_idx_q];
  assign ibuf.inst0      = data_q[rd_idx_q];
  assign ibuf.inst0_vld  = (count_q != '0);
  assign ibuf.inst1_addr = addr_q[rd_nxt];
  assign ibuf.inst1      = data_q[rd_nxt];
  assign ibuf.inst1_vld  = (count_q >= CW'(2));
endmodule

// File: doc/c7bifu_ibuf.md
# c7bifu_ibuf

Parametrised instruction buffer between the BIU fetch-return path and decode.
- Accepts fetch beats of FETCH_WORDS 32-bit instructions per cycle.
- Drops leading words when the fetch address is not beat-aligned, e.g. after a branch into the middle of a beat.
- Presents the two oldest instructions to a dual-lane decoder, which retires 0, 1 or 2 of them per cycle.

## Interface

Parameters:
- DEPTH, 8: instruction slots; power of two, at least 2*FETCH_WORDS.
- FETCH_WORDS, 2: instructions per fetch beat; power of two, 2 or 4.
- Derived: OW = log2(FETCH_WORDS); CW = log2(DEPTH)+1.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- data_addr  in  32  byte address of the fetched word; bits [1:0] ignored.
- data  in  32*FETCH_WORDS  fetch beat; word k sits at data[32k+31:32k].
- data_vld  in  1  beat valid.
- flush  in  1  synchronous discard of all contents.
- consume  in  2  number of lanes the decoder takes this cycle (0..2).
- iq_full  out  1  buffer cannot accept a beat.
- iq_count  out  CW  number of occupied slots.
- inst0_addr, inst0  out  32 each  oldest instruction and its address.
- inst0_vld  out  1  lane 0 valid.
- inst1_addr, inst1  out  32 each  second-oldest instruction and its address.
- inst1_vld  out  1  lane 1 valid.

## Operation

- State:
  - Storage arrays addr[DEPTH] and data[DEPTH].
  - wr_idx and rd_idx, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - count, CW bits.
- Full flag:
  - iq_full = (count > DEPTH - FETCH_WORDS).
  - Depends on the registered count only. It is conservative: it ignores the beat's offset and the same-cycle consume.
- Write acceptance:
  - A write is accepted when data_vld && !iq_full && !flush.
  - data_vld while full is ignored. Upstream must hold the beat.
- Offset handling:
  - off = data_addr[OW+1:2].
  - Only words k = off..FETCH_WORDS-1 are written, so n_wr = FETCH_WORDS - off.
  - Word k goes to slot (wr_idx + k - off) mod DEPTH.
  - Its address is {data_addr[31:OW+2], (OW+2) zero bits} + 4k.
  - After the write, wr_idx advances by n_wr.
- Read side:
  - n_rd = min(consume, number of valid lanes). Out-of-range consume values are clamped, never an error.
  - rd_idx advances by n_rd.
- Count update: count_next = count + n_wr - n_rd, with simultaneous write and read allowed.
- Output lanes:
  - Lanes are combinational from the head slot: lane 0 = slot rd_idx, lane 1 = slot (rd_idx+1) mod DEPTH.
  - inst0_vld = (count >= 1); inst1_vld = (count >= 2).
  - Lane addr/data are don't-care while the lane's vld is low.
- Flush:
  - Next cycle, wr_idx, rd_idx and count are 0.
  - A same-cycle write and consume are discarded.
  - Storage is not cleared.
- Reset:
  - Indices, count and all storage are 0.
  - Outputs after reset: iq_full=0, iq_count=0, inst*_vld=0, inst*_addr=0, inst*=0.
  - Reset asserted mid-operation behaves identically; any in-flight beat is lost.

## Timing

- Write-to-output latency is 1 cycle. An accepted beat is visible on the lanes in the following cycle.
- There is no combinational bypass from data_vld/data to the lanes, even when the buffer is empty.
- Consume takes effect at the clock edge. The new head appears the next cycle.
- No combinational path from consume or data_vld to iq_full or iq_count.
- Throughput:
  - One beat accepted per cycle while count <= DEPTH - FETCH_WORDS.
  - Up to 2 instructions retired per cycle.
- Boundary at full: with count = DEPTH-FETCH_WORDS, an accepted beat plus consume=2 leaves count = DEPTH-FETCH_WORDS+... (net +FETCH_WORDS-2).
  - For FETCH_WORDS=2 the count stays at 6 with DEPTH=8.

## Test plan

Defaults: DEPTH=8, FETCH_WORDS=2.

- Reset, then idle -> all outputs 0; iq_full=0; inst0_vld=inst1_vld=0.
- Beat addr=0x1000, data=0x22222222_11111111, consume=0 -> next cycle:
  - inst0=0x11111111 @0x1000 and inst1=0x22222222 @0x1004;
  - both lanes valid; iq_count=2.
- Unaligned beat addr=0x2004, data=0xBBBBBBBB_AAAAAAAA into an empty buffer -> only 0xBBBBBBBB @0x2004 stored:
  - iq_count=1; inst1_vld=0.
- Four aligned beats with consume=0 -> iq_count 2,4,6,8; iq_full=1 once count>=7.
  - A fifth data_vld is ignored and count stays 8.
  - Then consume=2 drops count to 6.
- Streaming with consume=1 every cycle across index 7->0:
  - lane order and addresses stay strictly sequential through the wrap;
  - consume=2 while count=1 retires only 1.
- flush asserted together with data_vld=1 and consume=2 at count=5 -> next cycle:
  - iq_count=0; inst*_vld=0; iq_full=0;
  - the beat is not stored, and a beat on the following cycle appears normally.
